pipe_adder_param: RTL and testbench

Parametrised, pipelined ripple-segment adder. Splits a WIDTH-bit add of `a + b + cin` into STAGES equal slices, one slice per pipeline register, with the inter-slice carry registered between stages. A valid/ready handshake on both sides supports backpressure, and a synchronous flush discards in-flight work. This is the general-purpose adder for the pipeline datapath and replaces fixed-width combinational adders wherever the carry chain limits timing.

---
 rtl/pipe_adder_param_if.sv | 38 +++
 rtl/pipe_adder_param.sv | 112 +++++++++++
 tb/tb_pipe_adder_param.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_param_if.sv
// Operand/result handshake bundle for pipe_adder_param.
// Carries the ovf result line only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_param_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef PIPE_ADDER_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
`endif
endinterface

// File: rtl/pipe_adder_param.sv
// Pipelined ripple-segment adder: one SW-bit slice per stage, carry registered between stages.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder_param #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   pipe_adder_param_if.slave  bus
);

   localparam int SW = WIDTH / STAGES;

   // Stage registers, index k = stage k (1..STAGES)
   logic             vld_p  [1:STAGES];
   logic             c_p    [1:STAGES];
   logic [WIDTH-1:0] psum_p [1:STAGES];
   logic [WIDTH-1:0] opa_p  [1:STAGES];
   logic [WIDTH-1:0] opb_p  [1:STAGES];

   // Values presented to each stage by its upstream neighbour
   logic             src_v    [1:STAGES];
   logic             src_c    [1:STAGES];
   logic [WIDTH-1:0] src_psum [1:STAGES];
   logic [WIDTH-1:0] src_a    [1:STAGES];
   logic [WIDTH-1:0] src_b    [1:STAGES];

   logic [WIDTH-1:0] nxt_psum [1:STAGES];
   logic             nxt_c    [1:STAGES];

   logic [STAGES:1]  en;
   logic             accept;

   // Enable chain: a stage may load when it is empty or its successor moves
   always_comb begin
      logic run;
      en  = '0;
      run = bus.out_ready;
      for (int k = STAGES; k >= 1; k--) begin
         run   = !vld_p[k] || run;
         en[k] = run;
      end
   end

   assign bus.in_ready = en[1] && !flush;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      src_v[1]    = accept;
      src_c[1]    = bus.cin;
      src_psum[1] = '0;
      src_a[1]    = bus.a;
      src_b[1]    = bus.b;
      for (int k = 2; k <= STAGES; k++) begin
         src_v[k]    = vld_p[k-1];
         src_c[k]    = c_p[k-1];
         src_psum[k] = psum_p[k-1];
         src_a[k]    = opa_p[k-1];
         src_b[k]    = opb_p[k-1];
      end
   end

   // Slice adders: stage k resolves bits [(k-1)*SW +: SW] of the result
   always_comb begin
      logic [SW:0] ssum;
      ssum = '0;
      for (int k = 1; k <= STAGES; k++) begin
         ssum = {1'b0, src_a[k][(k-1)*SW +: SW]}
              + {1'b0, src_b[k][(k-1)*SW +: SW]}
              + {{SW{1'b0}}, src_c[k]};
         nxt_psum[k]                = src_psum[k];
         nxt_psum[k][(k-1)*SW +: SW] = ssum[SW-1:0];
         nxt_c[k]                   = ssum[SW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= STAGES; k++) begin
            vld_p[k]  <= 1'b0;
            c_p[k]    <= 1'b0;
            psum_p[k] <= '0;
            opa_p[k]  <= '0;
            opb_p[k]  <= '0;
         end
      end else begin
         for (int k = 1; k <= STAGES; k++) begin
            if (flush) begin
               vld_p[k] <= 1'b0;
            end else if (en[k]) begin
               vld_p[k]  <= src_v[k];
               c_p[k]    <= nxt_c[k];
               psum_p[k] <= nxt_psum[k];
               opa_p[k]  <= src_a[k];
               opb_p[k]  <= src_b[k];
            end
         end
      end
   end

   // Output stage
   assign bus.out_valid = vld_p[STAGES];
   assign bus.sum       = psum_p[STAGES];
   assign bus.cout      = c_p[STAGES];

`ifdef PIPE_ADDER_OVF_EN
   assign bus.ovf = (opa_p[STAGES][WIDTH-1] == opb_p[STAGES][WIDTH-1])
                 && (psum_p[STAGES][WIDTH-1] != opa_p[STAGES][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipe_adder_param.sv
// Directed bench for pipe_adder_param (WIDTH=32): reset, ripple, stream, backpressure, flush, reset mid-run.
module tb_pipe_adder_param #(
   parameter int STAGES = 4
);

   logic clk = 1'b0;
   logic rst;
   logic flush;

   always #5 clk = ~clk;

   pipe_adder_param_if #(.WIDTH(32)) bus ();

   pipe_adder_param #(.WIDTH(32), .STAGES(STAGES)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand set, then wait (bounded) for its result to appear
   task automatic wait_out(input string tag, input logic [31:0] a, input logic [31:0] b, input logic cin);
      int lat;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.in_valid = 1'b1;
      #1;
      check_val({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < STAGES + 4) begin
         tick();
         lat++;
      end
      check_val({tag, "_lat"}, 64'(lat), 64'(STAGES));
   endtask

   function automatic logic [32:0] bp_res(input int k);
      logic [31:0] a;
      logic [31:0] b;
      a = 32'h89AB_CDEF + 32'h1111_1111 * 32'(k);
      b = 32'h7654_3210 + 32'(k);
      return {1'b0, a} + {1'b0, b} + 33'(k & 1);
   endfunction

   initial begin
      int          n;
      int          sent;
      int          rcv;
      int          infl;
      bit          acc;
      bit          pop;
      bit          stalled;
      logic [31:0] held;
      logic [32:0] r;

      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check_val("rst_valid", 64'(bus.out_valid), 64'd0);
      check_val("rst_sum",   64'(bus.sum),       64'd0);
      check_val("rst_cout",  64'(bus.cout),      64'd0);
      check_val("rst_ready", 64'(bus.in_ready),  64'd1);
`ifdef PIPE_ADDER_OVF_EN
      check_val("rst_ovf",   64'(bus.ovf),       64'd0);
`endif
      rst = 1'b0;
      tick();

      // Full-width carry ripple
      wait_out("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      check_val("ripple_sum",  64'(bus.sum),  64'h0);
      check_val("ripple_cout", 64'(bus.cout), 64'd1);
      tick();
      check_val("ripple_pulse", 64'(bus.out_valid), 64'd0);

      // Back-to-back stream of 8
      n = 0;
      for (int cyc = 0; cyc < STAGES + 14; cyc++) begin
         if (cyc < 8) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'(cyc);
            bus.b        = 32'h10 * 32'(cyc);
            bus.cin      = cyc[0];
         end else begin
            bus.in_valid = 1'b0;
         end
         tick();
         if (bus.out_valid) begin
            if (n < 8) begin
               check_val("stream_sum",  64'(bus.sum),  64'(32'h11 * 32'(n) + 32'(n & 1)));
               check_val("stream_cout", 64'(bus.cout), 64'd0);
               check_val("stream_cyc",  64'(cyc),      64'(STAGES - 1 + n));
            end
            n++;
         end
      end
      check_val("stream_cnt", 64'(n), 64'd8);

      // Backpressure: 5 ops, consumer stalls in cycles 5..8
      sent    = 0;
      rcv     = 0;
      infl    = 0;
      stalled = 1'b0;
      held    = '0;
      for (int cyc = 0; cyc < STAGES + 30; cyc++) begin
         bus.out_ready = !(cyc >= 5 && cyc <= 8);
         bus.in_valid  = (sent < 5);
         bus.a         = 32'h89AB_CDEF + 32'h1111_1111 * 32'(sent);
         bus.b         = 32'h7654_3210 + 32'(sent);
         bus.cin       = sent[0];
         #1;
         check_val("bp_in_ready", 64'(bus.in_ready), 64'(bus.out_ready || infl < STAGES));
         if (stalled && bus.out_valid)
            check_val("bp_hold", 64'(bus.sum), 64'(held));
         acc = bus.in_valid && bus.in_ready;
         pop = bus.out_valid && bus.out_ready;
         if (pop) begin
            r = bp_res(rcv);
            check_val("bp_sum",  64'(bus.sum),  64'(r[31:0]));
            check_val("bp_cout", 64'(bus.cout), 64'(r[32]));
            rcv++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held    = bus.sum;
         tick();
         if (acc) begin
            sent++;
            infl++;
         end
         if (pop) infl--;
      end
      check_val("bp_cnt", 64'(rcv), 64'd5);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      tick();

      // Flush drops three in-flight ops
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.a        = 32'(100 + k);
         bus.b        = 32'h0;
         bus.cin      = 1'b0;
         tick();
      end
      bus.in_valid = 1'b0;
      flush        = 1'b1;
      #1;
      check_val("flush_ready", 64'(bus.in_ready), 64'd0);
      tick();
      flush = 1'b0;
      check_val("flush_valid", 64'(bus.out_valid), 64'd0);
      wait_out("flush_next", 32'd5, 32'd7, 1'b0);
      check_val("flush_sum",  64'(bus.sum),  64'd12);
      check_val("flush_cout", 64'(bus.cout), 64'd0);
      tick();

`ifdef PIPE_ADDER_OVF_EN
      wait_out("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      check_val("ovf_pos_sum",  64'(bus.sum),  64'h8000_0000);
      check_val("ovf_pos_ovf",  64'(bus.ovf),  64'd1);
      check_val("ovf_pos_cout", 64'(bus.cout), 64'd0);
      tick();
      wait_out("ovf_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      check_val("ovf_wrap_sum",  64'(bus.sum),  64'h0);
      check_val("ovf_wrap_ovf",  64'(bus.ovf),  64'd0);
      check_val("ovf_wrap_cout", 64'(bus.cout), 64'd1);
      tick();
`endif

      // Reset mid-operation loses everything in flight
      for (int k = 0; k < 2; k++) begin
         bus.in_valid = 1'b1;
         bus.a        = 32'hDEAD_0000 + 32'(k);
         bus.b        = 32'hFFFF_FFFF;
         bus.cin      = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      tick();
      rst = 1'b0;
      check_val("mrst_valid", 64'(bus.out_valid), 64'd0);
      check_val("mrst_sum",   64'(bus.sum),       64'd0);
      check_val("mrst_cout",  64'(bus.cout),      64'd0);
      n = 0;
      for (int k = 0; k < STAGES + 2; k++) begin
         tick();
         if (bus.out_valid) n++;
      end
      check_val("mrst_quiet", 64'(n), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
